// File: rtl/wtm_seq_pkg.sv
// Shared types and constants for the sequenced 8x8 Wallace-tree multiplier.
// The optional signed mode is selected by the WTM_SEQ_SIGNED_EN macro.
package wtm_seq_pkg;

   localparam int STEPS  = 4;
   localparam int NIB_W  = 4;
   localparam int OP_W   = 8;
   localparam int PROD_W = 16;
   localparam int K_W    = $clog2(STEPS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Two's complement magnitude; -128 maps to 8'h80 as an unsigned value.
   function automatic logic [OP_W-1:0] abs_op(input logic [OP_W-1:0] v);
      return v[OP_W-1] ? (~v + 8'd1) : v;
   endfunction

endpackage

// File: rtl/wtm_seq8_wtm.sv
// 4x4 unsigned Wallace tree multiplier: one carry-save layer, then a final adder.
module wtm
   import wtm_seq_pkg::*;
(
   input  logic [NIB_W-1:0]   x,
   input  logic [NIB_W-1:0]   y,
   output logic [2*NIB_W-1:0] prod
);

   logic [NIB_W-1:0] pp [NIB_W];
   logic s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;
   logic [7:0] row0, row1, row2;

   always_comb begin
      for (int i = 0; i < NIB_W; i++) begin
         pp[i] = {NIB_W{x[i]}} & y;
      end
   end

   // pp[i][j] has weight i+j; each column of height >= 2 is compressed once.
   assign {c1, s1} = {1'b0, pp[0][1]} + {1'b0, pp[1][0]};
   assign {c2, s2} = {1'b0, pp[0][2]} + {1'b0, pp[1][1]} + {1'b0, pp[2][0]};
   assign {c3, s3} = {1'b0, pp[0][3]} + {1'b0, pp[1][2]} + {1'b0, pp[2][1]};
   assign {c4, s4} = {1'b0, pp[1][3]} + {1'b0, pp[2][2]} + {1'b0, pp[3][1]};
   assign {c5, s5} = {1'b0, pp[2][3]} + {1'b0, pp[3][2]};

   assign row0 = {1'b0, pp[3][3], s5, s4, s3, s2, s1, pp[0][0]};
   assign row1 = {1'b0, c5, c4, c3, c2, c1, 2'b00};
   assign row2 = {4'b0000, pp[3][0], 3'b000};

   assign prod = row0 + row1 + row2;

endmodule

// File: rtl/wtm_seq8.sv
// Sequenced 8x8 multiplier reusing one 4x4 Wallace core over four steps.
// Define WTM_SEQ_SIGNED_EN for two's complement operands and product.
module wtm_seq8
   import wtm_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] p,
   output logic              busy
);

   state_t             state_q, state_d;
   logic [K_W-1:0]     k_q, k_d;
   logic [OP_W-1:0]    a_q, a_d, b_q, b_d;
   logic [PROD_W-1:0]  acc_q, acc_d;
   logic [NIB_W-1:0]   nib_a, nib_b;
   logic [2*NIB_W-1:0] core_prod;
   logic [PROD_W-1:0]  part;
`ifdef WTM_SEQ_SIGNED_EN
   logic               sign_q, sign_d;
`endif

   // k[0] picks the a nibble, k[1] the b nibble.
   assign nib_a = k_q[0] ? a_q[7:4] : a_q[3:0];
   assign nib_b = k_q[1] ? b_q[7:4] : b_q[3:0];

   wtm u_wtm (
      .x    (nib_a),
      .y    (nib_b),
      .prod (core_prod)
   );

   always_comb begin
      case (k_q)
         2'd0:    part = {8'h00, core_prod};
         2'd1,
         2'd2:    part = {4'h0, core_prod, 4'h0};
         default: part = {core_prod, 8'h00};
      endcase
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
`ifdef WTM_SEQ_SIGNED_EN
      sign_d  = sign_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
`ifdef WTM_SEQ_SIGNED_EN
               a_d    = abs_op(a);
               b_d    = abs_op(b);
               sign_d = a[OP_W-1] ^ b[OP_W-1];
`else
               a_d    = a;
               b_d    = b;
`endif
               acc_d   = '0;
               k_d     = '0;
               state_d = MUL;
            end
         end
         MUL: begin
            acc_d = acc_q + part;
            if (k_q == K_W'(STEPS - 1)) begin
               state_d = DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
`ifdef WTM_SEQ_SIGNED_EN
         sign_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
`ifdef WTM_SEQ_SIGNED_EN
         sign_q  <= sign_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);

`ifdef WTM_SEQ_SIGNED_EN
   assign p = sign_q ? (~acc_q + 16'd1) : acc_q;
`else
   assign p = acc_q;
`endif

endmodule

// File: tb/tb_wtm_seq8.sv
// Self-checking bench for wtm_seq8: directed vectors plus a randomized
// back-to-back run scored against an arithmetic reference model.
module tb_wtm_seq8;

   logic        clk;
   logic        rst;
   logic        inValid;
   logic        inReady;
   logic [7:0]  aIn;
   logic [7:0]  bIn;
   logic        outValid;
   logic        outReady;
   logic [15:0] pOut;
   logic        busy;

   int assertCount = 0;
   int failCount   = 0;

   wtm_seq8 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .a         (aIn),
      .b         (bIn),
      .out_valid (outValid),
      .out_ready (outReady),
      .p         (pOut),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global safety net so the run can never hang.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Plain arithmetic product, 16-bit result.
   function automatic logic [15:0] refModel(input logic [7:0] x, input logic [7:0] y);
      int full;
`ifdef WTM_SEQ_SIGNED_EN
      full = int'($signed(x)) * int'($signed(y));
`else
      full = int'(x) * int'(y);
`endif
      return full[15:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // One full transaction with out_ready already high; checks latency and result.
   task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic [15:0] expected);
      int cycles;
      @(negedge clk);
      aIn     = x;
      bIn     = y;
      inValid = 1'b1;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      checkOutput("accept_in_ready_low", inReady, 0);
      checkOutput("accept_busy_high", busy, 1);
      cycles = 0;
      while (!outValid && cycles < 20) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput("latency", cycles, 4);
      checkOutput("product", pOut, expected);
      @(posedge clk);
      #1;
      checkOutput("post_in_ready", inReady, 1);
      checkOutput("post_out_valid", outValid, 0);
   endtask

   logic [7:0]  dirA   [];
   logic [7:0]  dirB   [];
   logic [15:0] dirExp [];
   logic [15:0] bpExp;

   initial begin
      int cycles;
      int seen;
      int sent;
      int got;
      bit acceptedLast;
      logic [15:0] expQ [$];
      logic [15:0] heldP;

`ifdef WTM_SEQ_SIGNED_EN
      dirA   = '{8'h80, 8'h80, 8'hFF, 8'h00};
      dirB   = '{8'h80, 8'h7F, 8'h01, 8'h37};
      dirExp = '{16'h4000, 16'hC080, 16'hFFFF, 16'h0000};
      bpExp  = 16'hFBBC;
`else
      dirA   = '{8'hFF, 8'h0C, 8'h00};
      dirB   = '{8'hFF, 8'hA5, 8'h37};
      dirExp = '{16'hFE01, 16'h07BC, 16'h0000};
      bpExp  = 16'h07BC;
`endif

      rst      = 1'b1;
      inValid  = 1'b0;
      outReady = 1'b1;
      aIn      = 8'h00;
      bIn      = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_in_ready", inReady, 1);
      checkOutput("reset_out_valid", outValid, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_p", pOut, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] directed vectors");
      foreach (dirA[i]) applyStimulus(dirA[i], dirB[i], dirExp[i]);

      $display("[TB] backpressure");
      outReady = 1'b0;
      @(negedge clk);
      aIn     = 8'h0C;
      bIn     = 8'hA5;
      inValid = 1'b1;
      @(posedge clk);
      #1;
      aIn = 8'h11;
      bIn = 8'h22;
      cycles = 0;
      while (!outValid && cycles < 20) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput("bp_latency", cycles, 4);
      checkOutput("bp_product", pOut, bpExp);
      heldP = pOut;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         checkOutput("bp_out_valid_hold", outValid, 1);
         checkOutput("bp_p_hold", pOut, heldP);
         checkOutput("bp_in_ready_low", inReady, 0);
      end
      @(negedge clk);
      inValid  = 1'b0;
      outReady = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (outValid) seen++;
      end
      checkOutput("bp_no_extra_product", seen, 0);

      $display("[TB] reset mid-operation");
      @(negedge clk);
      aIn     = 8'hFF;
      bIn     = 8'hFF;
      inValid = 1'b1;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midrst_in_ready", inReady, 1);
      checkOutput("midrst_out_valid", outValid, 0);
      checkOutput("midrst_p", pOut, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (outValid) seen++;
      end
      checkOutput("midrst_no_product", seen, 0);
      applyStimulus(8'h03, 8'h05, 16'h000F);

      $display("[TB] back-to-back random");
      sent = 0;
      got = 0;
      cycles = 0;
      acceptedLast = 1'b0;
      @(negedge clk);
      aIn     = 8'($urandom);
      bIn     = 8'($urandom);
      inValid = 1'b1;
      while (got < 8 && cycles < 600) begin
         if (acceptedLast) begin
            sent++;
            if (sent < 8) begin
               aIn = 8'($urandom);
               bIn = 8'($urandom);
            end else begin
               inValid = 1'b0;
            end
         end
         acceptedLast = inValid && inReady;
         if (acceptedLast) expQ.push_back(refModel(aIn, bIn));
         outReady = 1'($urandom_range(0, 1));
         if (outValid && outReady) begin
            checkOutput("b2b_expected_pending", (expQ.size() != 0), 1);
            if (expQ.size() != 0) checkOutput("b2b_product", pOut, expQ.pop_front());
            got++;
         end
         @(negedge clk);
         cycles++;
      end
      checkOutput("b2b_count", got, 8);
      checkOutput("b2b_leftover", expQ.size(), 0);
      outReady = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (outValid) seen++;
      end
      checkOutput("b2b_no_duplicate", seen, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
